// File: rtl/bc_pkg.sv
// Shared types, constants and helpers for the Bulls & Cows turn controller.
// The secret-validity helper is only referenced when BC_SECRET_CHECK_EN is defined.
package bc_pkg;

   localparam int DIGITS   = 4;
   localparam int NIBBLE_W = 4;
   localparam int COUNT_W  = 3;

   typedef enum logic [2:0] {
      SET1  = 3'd0,
      SET2  = 3'd1,
      GUESS = 3'd2,
      SCORE = 3'd3,
      SHOW  = 3'd4,
      DONE  = 3'd5
   } phase_t;

   // A secret is playable only if every digit is BCD and no digit repeats.
   function automatic logic secret_ok(input logic [DIGITS*NIBBLE_W-1:0] s);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[i*NIBBLE_W +: NIBBLE_W] > 4'd9) ok = 1'b0;
         for (int j = i + 1; j < DIGITS; j++) begin
            if (s[i*NIBBLE_W +: NIBBLE_W] == s[j*NIBBLE_W +: NIBBLE_W]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

   function automatic logic [3:0] dec_sat(input logic [3:0] v);
      return (v == 4'd0) ? 4'd0 : v - 4'd1;
   endfunction

endpackage

// File: rtl/bc_turn_timer.sv
// Loadable 8-bit per-guess down-counter; holds at zero and flags expiry.
module bc_turn_timer (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       tick,
   input  logic [7:0] value,
   output logic [7:0] count,
   output logic       expired
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= value;
      end else if (load) begin
         count <= value;
      end else if (tick && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign expired = (count == 8'd0);

endmodule

// File: rtl/bc_turn_controller.sv
// Two-player Bulls & Cows turn sequencer: secrets, turn timing, scorer handshake, win/draw.
// Optional secret validation is built only when BC_SECRET_CHECK_EN is defined.
//
// state | meaning
// SET1  | waiting for player 1 secret
// SET2  | waiting for player 2 secret
// GUESS | active player entering a guess, turn timer running
// SCORE | guess held on the scorer interface until ack
// SHOW  | result displayed, enter hands over to the other player
// DONE  | win or draw held, enter restarts the game
module bc_turn_controller
   import bc_pkg::*;
#(
   parameter int MAX_TURNS = 10,
   parameter int TURN_TIME = 30
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enter,
   input  logic        tick,
   input  logic [15:0] sw,
   output logic        score_req,
   output logic [15:0] score_secret,
   output logic [15:0] score_guess,
   input  logic        score_ack,
   input  logic [2:0]  score_bulls,
   input  logic [2:0]  score_cows,
   output phase_t      phase,
   output logic        active_player,
   output logic [3:0]  turns_left,
   output logic [7:0]  time_left,
   output logic [2:0]  last_bulls,
   output logic [2:0]  last_cows,
   output logic        timed_out,
   output logic        p1_win,
   output logic        p2_win,
   output logic        draw,
   output logic        reject
);

   localparam logic [3:0] TURNS_INIT = 4'(MAX_TURNS);
   localparam logic [7:0] TIME_INIT  = 8'(TURN_TIME);

   logic [15:0] secret1;
   logic [15:0] secret2;
   logic [3:0]  turns_other;
   logic        sw_ok;
   logic        exhausted;
   logic        restart;
   logic        timer_load;
   logic        timer_tick;
   logic        expired;

`ifdef BC_SECRET_CHECK_EN
   logic reject_q;

   assign sw_ok = secret_ok(sw);

   always_ff @(posedge clock) begin
      if (!reset) begin
         reject_q <= 1'b0;
      end else begin
         reject_q <= enter && ((phase == SET1) || (phase == SET2)) && !sw_ok;
      end
   end

   assign reject = reject_q;
`else
   assign sw_ok  = 1'b1;
   assign reject = 1'b0;
`endif

   // turns_left always shows the active player; turns_other is swapped in on hand-over.
   assign exhausted  = (turns_left == 4'd0) && (turns_other == 4'd0);
   assign restart    = (phase == DONE) && enter;
   assign timer_load = restart
                     || ((phase == SET2) && enter && sw_ok)
                     || ((phase == SHOW) && enter && !exhausted);
   assign timer_tick = tick && (phase == GUESS);

   bc_turn_timer u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (timer_load),
      .tick    (timer_tick),
      .value   (TIME_INIT),
      .count   (time_left),
      .expired (expired)
   );

   always_ff @(posedge clock) begin
      if (!reset || restart) begin
         phase         <= SET1;
         active_player <= 1'b0;
         turns_left    <= TURNS_INIT;
         turns_other   <= TURNS_INIT;
         secret1       <= '0;
         secret2       <= '0;
         score_req     <= 1'b0;
         score_secret  <= '0;
         score_guess   <= '0;
         last_bulls    <= '0;
         last_cows     <= '0;
         timed_out     <= 1'b0;
         p1_win        <= 1'b0;
         p2_win        <= 1'b0;
         draw          <= 1'b0;
      end else begin
         case (phase)
            SET1: begin
               if (enter && sw_ok) begin
                  secret1 <= sw;
                  phase   <= SET2;
               end
            end
            SET2: begin
               if (enter && sw_ok) begin
                  secret2       <= sw;
                  active_player <= 1'b0;
                  turns_left    <= TURNS_INIT;
                  turns_other   <= TURNS_INIT;
                  phase         <= GUESS;
               end
            end
            GUESS: begin
               // enter beats a timeout landing in the same cycle
               if (enter) begin
                  score_guess  <= sw;
                  score_secret <= active_player ? secret1 : secret2;
                  score_req    <= 1'b1;
                  phase        <= SCORE;
               end else if (expired) begin
                  timed_out  <= 1'b1;
                  last_bulls <= '0;
                  last_cows  <= '0;
                  turns_left <= dec_sat(turns_left);
                  phase      <= SHOW;
               end
            end
            SCORE: begin
               if (score_ack) begin
                  score_req  <= 1'b0;
                  last_bulls <= score_bulls;
                  last_cows  <= score_cows;
                  timed_out  <= 1'b0;
                  turns_left <= dec_sat(turns_left);
                  if (score_bulls == COUNT_W'(DIGITS)) begin
                     p1_win <= !active_player;
                     p2_win <= active_player;
                     phase  <= DONE;
                  end else begin
                     phase <= SHOW;
                  end
               end
            end
            SHOW: begin
               if (enter) begin
                  if (exhausted) begin
                     draw  <= 1'b1;
                     phase <= DONE;
                  end else begin
                     active_player <= !active_player;
                     turns_left    <= turns_other;
                     turns_other   <= turns_left;
                     phase         <= GUESS;
                  end
               end
            end
            DONE: begin
            end
            default: phase <= SET1;
         endcase
      end
   end

endmodule

// File: tb/tb_bc_turn_controller.sv
// Self-checking bench for bc_turn_controller: the bench plays both players and the scorer,
// with a scoreboard of expected scorer transactions and a small turn-budget model.
module tb_bc_turn_controller;

   localparam int MAXT = 10;
   localparam int TT   = 3;

   localparam int P_SET1  = 0;
   localparam int P_SET2  = 1;
   localparam int P_GUESS = 2;
   localparam int P_SCORE = 3;
   localparam int P_SHOW  = 4;
   localparam int P_DONE  = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enter = 1'b0;
   logic        tick = 1'b0;
   logic [15:0] sw = '0;
   logic        score_req;
   logic [15:0] score_secret;
   logic [15:0] score_guess;
   logic        score_ack = 1'b0;
   logic [2:0]  score_bulls = '0;
   logic [2:0]  score_cows = '0;
   bc_pkg::phase_t phase;
   logic        active_player;
   logic [3:0]  turns_left;
   logic [7:0]  time_left;
   logic [2:0]  last_bulls;
   logic [2:0]  last_cows;
   logic        timed_out;
   logic        p1_win;
   logic        p2_win;
   logic        draw;
   logic        reject;

   bc_turn_controller #(.MAX_TURNS(MAXT), .TURN_TIME(TT)) dut (
      .clock(clock), .reset(reset), .enter(enter), .tick(tick), .sw(sw),
      .score_req(score_req), .score_secret(score_secret), .score_guess(score_guess),
      .score_ack(score_ack), .score_bulls(score_bulls), .score_cows(score_cows),
      .phase(phase), .active_player(active_player), .turns_left(turns_left),
      .time_left(time_left), .last_bulls(last_bulls), .last_cows(last_cows),
      .timed_out(timed_out), .p1_win(p1_win), .p2_win(p2_win), .draw(draw),
      .reject(reject)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] secret;
      logic [15:0] guess;
   } sb_t;

   sb_t         sb_q[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_player;
   int          exp_t[2];
   logic [15:0] sec1;
   logic [15:0] sec2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [15:0] v);
      sw = v;
      enter = 1'b1;
      step();
      enter = 1'b0;
   endtask

   function automatic void score_model(input logic [15:0] s, input logic [15:0] g,
                                       output int b, output int c);
      b = 0;
      c = 0;
      for (int i = 0; i < 4; i++) begin
         if (g[4*i +: 4] == s[4*i +: 4]) begin
            b++;
         end else begin
            for (int j = 0; j < 4; j++) begin
               if (j != i && g[4*i +: 4] == s[4*j +: 4]) begin
                  c++;
                  break;
               end
            end
         end
      end
   endfunction

   function automatic int dec(input int v);
      return (v == 0) ? 0 : v - 1;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_phase"}, phase, P_SET1);
      chk({tag, "_player"}, active_player, 0);
      chk({tag, "_turns"}, turns_left, MAXT);
      chk({tag, "_time"}, time_left, TT);
      chk({tag, "_req"}, score_req, 0);
      chk({tag, "_secret"}, score_secret, 0);
      chk({tag, "_guess"}, score_guess, 0);
      chk({tag, "_bulls"}, last_bulls, 0);
      chk({tag, "_cows"}, last_cows, 0);
      chk({tag, "_tout"}, timed_out, 0);
      chk({tag, "_wins"}, {p1_win, p2_win, draw}, 0);
      chk({tag, "_reject"}, reject, 0);
   endtask

   task automatic start_game(input logic [15:0] s1, input logic [15:0] s2);
      press(s1);
      chk("sg_set2", phase, P_SET2);
      press(s2);
      chk("sg_guess", phase, P_GUESS);
      chk("sg_player", active_player, 0);
      chk("sg_turns", turns_left, MAXT);
      chk("sg_time", time_left, TT);
      sec1 = s1;
      sec2 = s2;
      exp_player = 0;
      exp_t[0] = MAXT;
      exp_t[1] = MAXT;
   endtask

   function automatic logic [15:0] opp_secret();
      return (exp_player == 0) ? sec2 : sec1;
   endfunction

   task automatic submit(input logic [15:0] g);
      sb_q.push_back('{secret: opp_secret(), guess: g});
      press(g);
      chk("sub_phase", phase, P_SCORE);
      chk("sub_req", score_req, 1);
   endtask

   // Acts as the scorer for the oldest outstanding guess.
   task automatic serve(input int delay);
      sb_t e;
      int  b;
      int  c;
      int  n = 0;
      while (!score_req && n < 10) begin
         step();
         n++;
      end
      if (!score_req) begin
         chk("req_wait", score_req, 1);
         return;
      end
      e = sb_q.pop_front();
      chk("sv_secret", score_secret, e.secret);
      chk("sv_guess", score_guess, e.guess);
      score_model(e.secret, e.guess, b, c);
      for (int k = 0; k < delay; k++) begin
         if (k == 5) begin
            sw = 16'hFFFF;
            enter = 1'b1;
         end
         step();
         enter = 1'b0;
         chk("hold_req", score_req, 1);
         chk("hold_guess", score_guess, e.guess);
         chk("hold_phase", phase, P_SCORE);
      end
      score_bulls = 3'(b);
      score_cows = 3'(c);
      score_ack = 1'b1;
      step();
      score_ack = 1'b0;
      exp_t[exp_player] = dec(exp_t[exp_player]);
      chk("ack_req", score_req, 0);
      chk("ack_bulls", last_bulls, b);
      chk("ack_cows", last_cows, c);
      chk("ack_tout", timed_out, 0);
      chk("ack_turns", turns_left, exp_t[exp_player]);
      if (b == 4) begin
         chk("win_phase", phase, P_DONE);
         chk("win_flags", {p1_win, p2_win, draw}, (exp_player == 0) ? 3'b100 : 3'b010);
      end else begin
         chk("ack_phase", phase, P_SHOW);
      end
   endtask

   task automatic timeout_turn();
      for (int k = 0; k < TT; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         chk("to_time", time_left, TT - 1 - k);
      end
      chk("to_still_guess", phase, P_GUESS);
      step();
      exp_t[exp_player] = dec(exp_t[exp_player]);
      chk("to_phase", phase, P_SHOW);
      chk("to_flag", timed_out, 1);
      chk("to_bulls", last_bulls, 0);
      chk("to_cows", last_cows, 0);
      chk("to_turns", turns_left, exp_t[exp_player]);
   endtask

   task automatic next_turn();
      press(16'h0000);
      if (exp_t[0] == 0 && exp_t[1] == 0) begin
         chk("nt_done", phase, P_DONE);
         chk("nt_draw", {p1_win, p2_win, draw}, 3'b001);
      end else begin
         exp_player ^= 1;
         chk("nt_phase", phase, P_GUESS);
         chk("nt_player", active_player, exp_player);
         chk("nt_turns", turns_left, exp_t[exp_player]);
         chk("nt_time", time_left, TT);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s1;
      repeat (3) step();
      check_reset_vals("rst");
      reset = 1'b1;
      step();

`ifdef BC_SECRET_CHECK_EN
      press(16'h1123);
      chk("rej_dup", reject, 1);
      chk("rej_dup_phase", phase, P_SET1);
      step();
      chk("rej_pulse_end", reject, 0);
      press(16'h1A23);
      chk("rej_hex", reject, 1);
      chk("rej_hex_phase", phase, P_SET1);
      s1 = 16'h1203;
      press(s1);
      chk("acc_reject", reject, 0);
      chk("acc_phase", phase, P_SET2);
      press(16'h1A23);
      chk("rej2_hex", reject, 1);
      chk("rej2_phase", phase, P_SET2);
      press(16'h5678);
`else
      s1 = 16'h1123;
      press(s1);
      chk("nochk_reject", reject, 0);
      chk("nochk_phase", phase, P_SET2);
      press(16'h5678);
`endif
      chk("g1_phase", phase, P_GUESS);
      sec1 = s1;
      sec2 = 16'h5678;
      exp_player = 0;
      exp_t[0] = MAXT;
      exp_t[1] = MAXT;

      // P1 all cows, then a stray ack outside SCORE
      submit(16'h8765);
      serve(0);
      chk("cows4", last_cows, 4);
      score_bulls = 3'd4;
      score_ack = 1'b1;
      step();
      score_ack = 1'b0;
      chk("stray_ack_phase", phase, P_SHOW);
      chk("stray_ack_bulls", last_bulls, 0);
      next_turn();

      // P2 slow scorer with an ignored enter during SCORE
      submit(16'h1243);
      serve(20);
      next_turn();

      timeout_turn();
      next_turn();

      // P2: enter together with the final tick wins over timeout
      tick = 1'b1;
      step();
      step();
      tick = 1'b0;
      chk("race_time", time_left, 1);
      sb_q.push_back('{secret: opp_secret(), guess: sec1});
      sw = sec1;
      enter = 1'b1;
      tick = 1'b1;
      step();
      enter = 1'b0;
      tick = 1'b0;
      chk("race_phase", phase, P_SCORE);
      serve(0);
      press(16'h0000);
      check_reset_vals("done1");

      // P1 wins on the first guess
      start_game(16'h1234, 16'h5678);
      submit(16'h5678);
      serve(1);
      chk("p1_turns9", turns_left, MAXT - 1);
      press(16'h0000);
      check_reset_vals("done2");

      // reset during SCORE, then a late ack
      start_game(16'h1234, 16'h5678);
      press(16'h5678);
      chk("rs_req_up", score_req, 1);
      reset = 1'b0;
      step();
      chk("rs_req_drop", score_req, 0);
      chk("rs_phase", phase, P_SET1);
      reset = 1'b1;
      score_bulls = 3'd4;
      score_cows = 3'd0;
      score_ack = 1'b1;
      step();
      score_ack = 1'b0;
      check_reset_vals("late_ack");

      // exhaust both budgets: draw after P2's last SHOW
      start_game(16'h1234, 16'h5678);
      for (int i = 0; i < 2 * MAXT; i++) begin
         if ((i % 4) < 2) begin
            submit(16'h9870);
            serve(0);
         end else begin
            timeout_turn();
         end
         next_turn();
      end
      chk("draw_phase", phase, P_DONE);
      chk("draw_flag", draw, 1);
      press(16'h0000);
      check_reset_vals("done3");

      chk("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bc_turn_controller.md
# bc_turn_controller

Turn sequencer for the two-player Bulls & Cows game. It captures both secrets, gives the shared switch bank and enter key to the active player, and enforces a per-turn time limit and a per-player attempt budget. It sends each guess to an external scorer over a req/ack handshake and declares a win or a draw. It sits between the edge-detected enter pulse and the scoring datapath, and drives the status consumed by the display formatter.

## Interface
Parameters:
- MAX_TURNS, 10, attempts per player, range 1..15
- TURN_TIME, 30, tick strobes allowed per guess, range 1..255

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- enter  in  1  one-cycle pulse, already edge-detected
- tick  in  1  one-cycle timebase strobe
- sw  in  16  four BCD nibbles; sw[3:0] is digit 0
- score_req  out  1  scoring request
- score_secret  out  16  secret to compare against
- score_guess  out  16  guess being scored
- score_ack  in  1  scorer result valid
- score_bulls  in  3  bulls count, 0..4
- score_cows  in  3  cows count, 0..4
- phase  out  3  current state (bc_pkg::phase_t)
- active_player  out  1  0 = P1, 1 = P2
- turns_left  out  4  attempts remaining for the active player
- time_left  out  8  ticks remaining in the current guess
- last_bulls, last_cows  out  3 each  most recent result
- timed_out  out  1  last turn was forfeited by timeout
- p1_win, p2_win, draw  out  1 each  held high while in DONE
- reject  out  1  one-cycle pulse when a secret is refused (only with BC_SECRET_CHECK_EN)

## Operation
States: SET1, SET2, GUESS, SCORE, SHOW, DONE.

- **SET1:** on enter, sw goes to secret1 and the block moves to SET2.
- **SET2:** on enter, sw goes to secret2. The block moves to GUESS with active_player=0. time_left loads TURN_TIME. Both turn counters load MAX_TURNS.
- **GUESS:** each tick decrements time_left.
  - On enter: latch sw as score_guess and set score_secret to the opponent's secret. Move to SCORE.
  - When time_left reaches 0 with no enter that cycle: the turn is forfeited. Set timed_out=1, last_bulls=0, last_cows=0, decrement the active turn counter, and move to SHOW.
- **SCORE:**
  - score_req stays high, and score_secret/score_guess stay stable, until score_ack is sampled high.
  - On ack: capture bulls/cows into last_*, clear timed_out, and decrement the active turn counter.
  - If bulls==4, go to DONE with the winner set. Otherwise go to SHOW.
- **SHOW:** on enter, run the exhaustion check.
  - If both turn counters are 0, go to DONE with draw=1.
  - Otherwise toggle active_player, reload time_left, and go to GUESS.
- **DONE:** win/draw outputs are held. On enter, clear all registers to reset values and go to SET1.

Rules and boundary conditions:
- enter is ignored in SCORE. score_ack is ignored outside SCORE. tick is ignored outside GUESS.
- If enter and the timeout expiry land in the same cycle, enter wins and the guess is scored.
- A player whose counter is 0 is not skipped. Exhaustion is checked only in SHOW, so the draw is declared after P2's final turn.
- turns_left saturates at 0 and never wraps.
- Reset asserted during SCORE drops score_req at that clock edge. A late ack arriving after reset is ignored.

## Timing
- Every output is registered.
- Reset values:
  - phase=SET1, active_player=0, turns_left=MAX_TURNS, time_left=TURN_TIME.
  - score_req=0, score_secret=0, score_guess=0.
  - last_bulls=0, last_cows=0, timed_out=0.
  - p1_win=0, p2_win=0, draw=0, reject=0.
- enter sampled at edge N gives the new phase at N+1. In GUESS, score_req rises at N+1.
- score_ack sampled at edge M gives score_req=0, last_* updated and the new phase at M+1.
- Minimum enter-to-SHOW latency is 2 cycles, with a same-cycle ack.
- time_left updates the cycle after the tick. Expiry at 0 changes phase on the following edge.

## Configuration
- BC_SECRET_CHECK_EN defined: in SET1/SET2 a secret with any nibble greater than 9, or any repeated nibble, is refused. reject pulses for one cycle and the state is unchanged.
- Undefined: any 16-bit value is accepted, reject is tied to 0, and no checker logic is built.

## Structure
- Package bc_pkg:
  - phase_t enum (SET1=0 .. DONE=5)
  - constants DIGITS=4, NIBBLE_W=4, COUNT_W=3
  - the secret-validity function, used under the macro
- Sub-module bc_turn_timer: a loadable 8-bit down-counter with inputs load, tick, value and outputs count and expired.

## Test plan
- Secrets 0x1234 / 0x5678, P1 guesses 0x5678, scorer returns bulls=4 -> DONE, p1_win=1, turns_left shows 9 for P1.
- P1 guesses 0x8765, scorer returns bulls=0 cows=4 -> SHOW, last_cows=4; enter -> GUESS, active_player=1.
- Hold score_ack low for 20 cycles -> score_req stays high and score_guess stays stable; ack gives req=0 one cycle later.
- TURN_TIME=3, three ticks with no enter -> SHOW, timed_out=1, last_bulls=0; enter and final tick together -> SCORE instead.
- MAX_TURNS=2, all guesses wrong -> draw=1 after P2's second SHOW+enter; enter in DONE -> SET1 with all reset values.
- BC_SECRET_CHECK_EN defined, secret 0x1123 -> reject pulse, phase stays SET1; 0x1A23 rejected; 0x1203 accepted.
